// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/response checker for small combinational boolean blocks.
// Walks every N_IN-bit vector in ascending order and compares the sampled responses against EXPECTED.
module truth_table_sweeper #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1,
    parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = 8'h3F
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [N_OUT-1:0]           resp_in,
    output logic [N_IN-1:0]            vec_out,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [N_IN:0]              err_count,
    output logic                       first_fail_valid,
    output logic [N_IN-1:0]            first_fail_idx,
    output logic [(2**N_IN)*N_OUT-1:0] captured
);

    localparam int NV = 2**N_IN;
    localparam int TW = NV*N_OUT;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_VEC    = N_IN'(NV-1);
    localparam logic [CW-1:0]   LAST_SETTLE = CW'(SETTLE-1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [CW-1:0]    settle_q, settle_d;
    logic [N_IN:0]    err_q, err_d;
    logic             ffv_q, ffv_d;
    logic [N_IN-1:0]  ffi_q, ffi_d;
    logic             pass_q, pass_d;
    logic [TW-1:0]    cap_q, cap_d;
    logic [N_OUT-1:0] exp_slice;
    logic             mismatch;

    // Case inequality so an undriven or unknown response is scored as a failure.
    always_comb begin
        exp_slice = EXPECTED[vec_q*N_OUT +: N_OUT];
        mismatch  = (resp_in !== exp_slice);
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffi_d    = ffi_q;
        pass_d   = pass_q;
        cap_d    = cap_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d    = '0;
                    ffv_d    = 1'b0;
                    ffi_d    = '0;
                    pass_d   = 1'b0;
                    cap_d    = '0;
                    vec_d    = '0;
                    settle_d = '0;
                    state_d  = S_APPLY;
                end
            end
            S_APPLY: begin
                if (settle_q == LAST_SETTLE) begin
                    cap_d[vec_q*N_OUT +: N_OUT] = resp_in;
                    if (mismatch) begin
                        err_d = err_q + (N_IN+1)'(1);
                        if (!ffv_q) begin
                            ffv_d = 1'b1;
                            ffi_d = vec_q;
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        // pass is settled on entry to DONE so it is valid alongside the done pulse.
                        pass_d  = (err_d == '0);
                        state_d = S_DONE;
                    end else begin
                        vec_d    = vec_q + N_IN'(1);
                        settle_d = '0;
                    end
                end else begin
                    settle_d = settle_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            ffv_q    <= 1'b0;
            ffi_q    <= '0;
            pass_q   <= 1'b0;
            cap_q    <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            ffv_q    <= ffv_d;
            ffi_q    <= ffi_d;
            pass_q   <= pass_d;
            cap_q    <= cap_d;
        end
    end

    assign vec_out          = vec_q;
    assign busy             = (state_q == S_APPLY);
    assign done             = (state_q == S_DONE);
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;
    assign captured         = cap_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: responses come from a per-vector lookup table and results are
// compared against a table-walking reference model of the fxy NAND pair.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       start1, busy1, done1, pass1, ffv1;
    logic [1:0] resp1, vec1, ffi1;
    logic [2:0] err1;
    logic [7:0] cap1;

    logic       start3, busy3, done3, pass3, ffv3;
    logic [1:0] resp3, vec3, ffi3;
    logic [2:0] err3;
    logic [7:0] cap3;

    logic [1:0] tbl1 [4];
    logic [1:0] tbl3 [4];
    logic       xmode1;

    always_comb resp1 = (xmode1 && vec1 == 2'd1) ? 2'bxx : tbl1[vec1];
    always_comb resp3 = tbl3[vec3];

    truth_table_sweeper u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .resp_in(resp1), .vec_out(vec1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_valid(ffv1), .first_fail_idx(ffi1), .captured(cap1)
    );

    truth_table_sweeper #(.SETTLE(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .resp_in(resp3), .vec_out(vec3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_fail_valid(ffv3), .first_fail_idx(ffi3), .captured(cap3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_err;
    logic       exp_ffv;
    logic [1:0] exp_ffi;
    logic       exp_pass;
    logic [7:0] exp_cap;

    function automatic logic [1:0] nand_resp(input int v);
        logic x, y;
        x = v[1];
        y = v[0];
        return {~(x & y), ~(x & y)};
    endfunction

    // Reference: count vectors whose response differs from the fxy truth table.
    task automatic model(input logic [1:0] t [4], input logic x_on_1);
        logic m;
        exp_err = 0; exp_ffv = 0; exp_ffi = 0; exp_cap = 0;
        for (int i = 0; i < 4; i++) begin
            m = (x_on_1 && i == 1) ? 1'b1 : (t[i] !== nand_resp(i));
            exp_cap[i*2 +: 2] = t[i];
            if (m) begin
                if (!exp_ffv) exp_ffi = 2'(i);
                exp_ffv = 1'b1;
                exp_err = exp_err + 3'd1;
            end
        end
        exp_pass = (exp_err == 0);
    endtask

    task automatic load_nand1();
        for (int i = 0; i < 4; i++) tbl1[i] = nand_resp(i);
    endtask

    // Pulses start, records vec_out each busy cycle, returns cycles from start edge to done.
    task automatic run_sweep1(output int lat, output int nseq, output logic [1:0] seq [16]);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 1; nseq = 0;
        while (done1 !== 1'b1 && lat < 100) begin
            if (nseq < 16) seq[nseq] = vec1;
            nseq++;
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start1 = 0; start3 = 0; xmode1 = 0;
        load_nand1();
        for (int i = 0; i < 4; i++) tbl3[i] = nand_resp(i);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (vec1 !== 2'd0) begin n_fail++; $display("FAIL reset_vec got %0d exp 0", vec1); end
        n_checks++; if ({busy1, done1, pass1, ffv1} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {busy1, done1, pass1, ffv1}); end
        n_checks++; if (err1 !== 3'd0 || ffi1 !== 2'd0) begin n_fail++; $display("FAIL reset_err got err=%0d idx=%0d exp 0/0", err1, ffi1); end
        n_checks++; if (cap1 !== 8'h00) begin n_fail++; $display("FAIL reset_cap got %h exp 00", cap1); end
        n_checks++; if ({busy3, done3, err3, cap3} !== '0) begin n_fail++; $display("FAIL reset_dut3 got busy=%b done=%b err=%0d cap=%h exp 0", busy3, done3, err3, cap3); end
        $display("test_reset: done");
    endtask

    task automatic test_fxy();
        int lat, nseq, bad;
        logic [1:0] seq [16];
        load_nand1();
        model(tbl1, 1'b0);
        run_sweep1(lat, nseq, seq);
        bad = 0;
        for (int k = 0; k < 4; k++) if (seq[k] !== 2'(k)) bad++;
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL fxy_latency got %0d exp 5", lat); end
        n_checks++; if (nseq !== 4 || bad !== 0) begin n_fail++; $display("FAIL fxy_sequence got len=%0d bad=%0d exp 4/0", nseq, bad); end
        n_checks++; if (err1 !== 3'd0 || pass1 !== 1'b1) begin n_fail++; $display("FAIL fxy_result got err=%0d pass=%b exp 0/1", err1, pass1); end
        n_checks++; if (cap1 !== 8'h3F || cap1 !== exp_cap) begin n_fail++; $display("FAIL fxy_captured got %h exp 3f", cap1); end
        n_checks++; if (ffv1 !== 1'b0) begin n_fail++; $display("FAIL fxy_ffv got %b exp 0", ffv1); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || cap1 !== 8'h3F || pass1 !== 1'b1 || vec1 !== 2'd3) begin
            n_fail++; $display("FAIL fxy_hold got busy=%b done=%b cap=%h pass=%b vec=%0d exp 0/0/3f/1/3", busy1, done1, cap1, pass1, vec1); end
        $display("test_fxy: latency %0d err %0d pass %b cap %h", lat, err1, pass1, cap1);
    endtask

    task automatic test_tied(input logic [1:0] v, input logic [2:0] want_err, input logic [1:0] want_idx, input logic [7:0] want_cap);
        int lat, nseq;
        logic [1:0] seq [16];
        for (int i = 0; i < 4; i++) tbl1[i] = v;
        model(tbl1, 1'b0);
        run_sweep1(lat, nseq, seq);
        n_checks++; if (err1 !== want_err || err1 !== exp_err) begin n_fail++; $display("FAIL tied%b_err got %0d exp %0d", v, err1, want_err); end
        n_checks++; if (ffv1 !== 1'b1 || ffi1 !== want_idx) begin n_fail++; $display("FAIL tied%b_first got v=%b idx=%0d exp 1/%0d", v, ffv1, ffi1, want_idx); end
        n_checks++; if (pass1 !== 1'b0) begin n_fail++; $display("FAIL tied%b_pass got %b exp 0", v, pass1); end
        n_checks++; if (cap1 !== want_cap || cap1 !== exp_cap) begin n_fail++; $display("FAIL tied%b_cap got %h exp %h", v, cap1, want_cap); end
        $display("test_tied %b: err %0d idx %0d cap %h", v, err1, ffi1, cap1);
    endtask

    task automatic test_x_response();
        int lat, nseq;
        logic [1:0] seq [16];
        load_nand1();
        xmode1 = 1'b1;
        model(tbl1, 1'b1);
        run_sweep1(lat, nseq, seq);
        xmode1 = 1'b0;
        n_checks++; if (err1 !== 3'd1 || err1 !== exp_err) begin n_fail++; $display("FAIL xresp_err got %0d exp 1", err1); end
        n_checks++; if (ffv1 !== 1'b1 || ffi1 !== 2'd1) begin n_fail++; $display("FAIL xresp_first got v=%b idx=%0d exp 1/1", ffv1, ffi1); end
        n_checks++; if (pass1 !== 1'b0) begin n_fail++; $display("FAIL xresp_pass got %b exp 0", pass1); end
        $display("test_x_response: err %0d idx %0d", err1, ffi1);
    endtask

    task automatic test_random();
        int lat, nseq;
        logic [1:0] seq [16];
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < 4; i++) tbl1[i] = 2'($urandom_range(3));
            model(tbl1, 1'b0);
            run_sweep1(lat, nseq, seq);
            n_checks++;
            if (lat !== 5 || err1 !== exp_err || pass1 !== exp_pass || ffv1 !== exp_ffv || cap1 !== exp_cap ||
                (exp_ffv && ffi1 !== exp_ffi)) begin
                n_fail++;
                $display("FAIL random%0d got lat=%0d err=%0d pass=%b ffv=%b idx=%0d cap=%h exp 5/%0d/%b/%b/%0d/%h",
                         it, lat, err1, pass1, ffv1, ffi1, cap1, exp_err, exp_pass, exp_ffv, exp_ffi, exp_cap);
            end
            $display("test_random %0d: cap %h err %0d pass %b", it, cap1, err1, pass1);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nseq;
        logic [1:0] seq [16];
        for (int i = 0; i < 4; i++) tbl1[i] = 2'b01;
        model(tbl1, 1'b0);
        run_sweep1(lat, nseq, seq);
        n_checks++; if (err1 !== exp_err || ffi1 !== exp_ffi || cap1 !== exp_cap) begin n_fail++; $display("FAIL b2b_first got err=%0d idx=%0d cap=%h exp %0d/%0d/%h", err1, ffi1, cap1, exp_err, exp_ffi, exp_cap); end
        load_nand1();
        model(tbl1, 1'b0);
        run_sweep1(lat, nseq, seq);
        n_checks++; if (lat !== 5 || err1 !== 3'd0 || ffv1 !== 1'b0 || pass1 !== 1'b1 || cap1 !== 8'h3F) begin
            n_fail++; $display("FAIL b2b_second got lat=%0d err=%0d ffv=%b pass=%b cap=%h exp 5/0/0/1/3f", lat, err1, ffv1, pass1, cap1); end
        $display("test_back_to_back: second sweep err %0d pass %b", err1, pass1);
    endtask

    task automatic test_settle3();
        int lat, nseq, bad, dones;
        logic busy_seen;
        logic [1:0] seq [16];
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat = 1; nseq = 0; dones = 0;
        while (done3 !== 1'b1 && lat < 200) begin
            if (nseq < 16) seq[nseq] = vec3;
            nseq++;
            start3 = (lat == 5);
            @(posedge clk); #1;
            start3 = 1'b0;
            lat++;
        end
        if (done3 === 1'b1) dones++;
        bad = 0;
        for (int k = 0; k < 12; k++) if (seq[k] !== 2'(k/3)) bad++;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        busy_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (done3 === 1'b1) dones++;
            if (busy3 !== 1'b0) busy_seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL settle3_latency got %0d exp 13", lat); end
        n_checks++; if (nseq !== 12 || bad !== 0) begin n_fail++; $display("FAIL settle3_hold got len=%0d bad=%0d exp 12/0", nseq, bad); end
        n_checks++; if (dones !== 1 || busy_seen !== 1'b0) begin n_fail++; $display("FAIL settle3_ignore got dones=%0d busy_seen=%b exp 1/0", dones, busy_seen); end
        n_checks++; if (err3 !== 3'd0 || pass3 !== 1'b1 || cap3 !== 8'h3F || ffv3 !== 1'b0) begin
            n_fail++; $display("FAIL settle3_result got err=%0d pass=%b cap=%h ffv=%b exp 0/1/3f/0", err3, pass3, cap3, ffv3); end
        $display("test_settle3: latency %0d dones %0d cap %h", lat, dones, cap3);
    endtask

    task automatic test_async_reset();
        int lat, nseq, guard;
        logic [1:0] seq [16];
        for (int i = 0; i < 4; i++) tbl1[i] = 2'b00;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        guard = 0;
        while (vec1 !== 2'd2 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++; if (vec1 !== 2'd2 || busy1 !== 1'b1 || err1 === 3'd0) begin n_fail++; $display("FAIL areset_setup got vec=%0d busy=%b err=%0d exp 2/1/nonzero", vec1, busy1, err1); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({vec1, busy1, done1, pass1, err1, ffv1, ffi1, cap1} !== '0) begin
            n_fail++; $display("FAIL areset_clear got vec=%0d busy=%b done=%b pass=%b err=%0d ffv=%b idx=%0d cap=%h exp all 0",
                               vec1, busy1, done1, pass1, err1, ffv1, ffi1, cap1); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy1 !== 1'b0 || vec1 !== 2'd0) begin n_fail++; $display("FAIL areset_idle got busy=%b vec=%0d exp 0/0", busy1, vec1); end
        load_nand1();
        run_sweep1(lat, nseq, seq);
        n_checks++; if (lat !== 5 || err1 !== 3'd0 || pass1 !== 1'b1 || cap1 !== 8'h3F) begin
            n_fail++; $display("FAIL areset_rerun got lat=%0d err=%0d pass=%b cap=%h exp 5/0/1/3f", lat, err1, pass1, cap1); end
        $display("test_async_reset: rerun latency %0d cap %h", lat, cap1);
    endtask

    initial begin
        test_reset();
        test_fxy();
        test_tied(2'b11, 3'd1, 2'd3, 8'hFF);
        test_tied(2'b00, 3'd3, 2'd0, 8'h00);
        test_x_response();
        test_random();
        test_back_to_back();
        test_settle3();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
